// File: rtl/weight_feeder.sv
// -----------------------------------------------------------------------------
// weight_feeder
//
// Loads one tile of ROWS weight words from a host stream into the inactive
// weight registers of a systolic-array column. Accepted words are shifted
// down the column one cycle after acceptance. Once the tile is full, the
// feeder waits for a compute boundary and then pulses the column's switch
// line to swap the inactive and active weights.
//
// Ports
//   clk                : single clock, rising-edge active
//   rst                : asynchronous, active-high reset
//   wf_start_in        : begin loading a tile (honoured in IDLE only)
//   wf_abort_in        : cancel the current tile from any state
//   wf_data_in         : host weight word, bottom row first
//   wf_data_valid_in   : host word valid
//   wf_data_ready_out  : feeder accepts a word this cycle (combinational)
//   wf_switch_en_in    : compute boundary reached, switch permitted
//   wf_accept_w_out    : column weight chain shifts when 1
//   wf_weight_out      : weight word into the top PE of the column
//   wf_switch_out      : inactive->active weight swap pulse
//   wf_count_out       : words accepted in the current tile
//   wf_busy_out        : feeder is not IDLE (combinational)
//   wf_done_out        : one-cycle pulse, tile switched in
// -----------------------------------------------------------------------------
module weight_feeder #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wf_start_in,
    input  logic                      wf_abort_in,
    input  logic [DATA_W-1:0]         wf_data_in,
    input  logic                      wf_data_valid_in,
    output logic                      wf_data_ready_out,
    input  logic                      wf_switch_en_in,
    output logic                      wf_accept_w_out,
    output logic [DATA_W-1:0]         wf_weight_out,
    output logic                      wf_switch_out,
    output logic [$clog2(ROWS+1)-1:0] wf_count_out,
    output logic                      wf_busy_out,
    output logic                      wf_done_out
);

    localparam int CNT_W = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_SW = 2'd2
    } state_e;

    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [DATA_W-1:0]   weight_q, weight_d;
    logic                accept_q, accept_d;
    logic                switch_q, switch_d;
    logic                done_q,   done_d;

    // Ready is combinational so that an abort in the same cycle blocks the
    // handshake; abort therefore always wins over a host word.
    assign wf_data_ready_out = (state_q == LOAD) && !wf_abort_in;
    assign wf_busy_out       = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        weight_d = weight_q;   // hold last word so the column sees no change on stall
        accept_d = 1'b0;
        switch_d = 1'b0;
        done_d   = 1'b0;

        if (wf_abort_in) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (wf_start_in) begin
                        state_d = LOAD;
                        count_d = '0;
                    end
                end
                LOAD: begin
                    // In this branch ready is 1, so valid alone completes the handshake.
                    if (wf_data_valid_in) begin
                        weight_d = wf_data_in;
                        accept_d = 1'b1;
                        count_d  = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(ROWS - 1)) begin
                            state_d = WAIT_SW;
                        end
                    end
                end
                WAIT_SW: begin
                    // Only entered after the last shift cycle has been issued,
                    // so switch can never coincide with accept_w.
                    if (wf_switch_en_in) begin
                        switch_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                        count_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            weight_q <= '0;
            accept_q <= 1'b0;
            switch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            weight_q <= weight_d;
            accept_q <= accept_d;
            switch_q <= switch_d;
            done_q   <= done_d;
        end
    end

    assign wf_accept_w_out = accept_q;
    assign wf_weight_out   = weight_q;
    assign wf_switch_out   = switch_q;
    assign wf_count_out    = count_q;
    assign wf_done_out     = done_q;

endmodule

// File: doc/weight_feeder.md
WEIGHT_FEEDER -- requirements
Module: weight_feeder

Interface
REQ-001 Parameter: DATA_W, 16, width of one Q8.8 weight word.
REQ-002 Parameter: ROWS, 4, number of PEs in the driven column (>=2) = weights per tile.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: wf_start_in  input  1  begin loading a tile; honoured in IDLE only.
REQ-006 Port: wf_abort_in  input  1  cancel current tile, any state.
REQ-007 Port: wf_data_in  input  DATA_W  weight word from host, bottom row first.
REQ-008 Port: wf_data_valid_in  input  1  host word valid.
REQ-009 Port: wf_data_ready_out  output  1  feeder accepts word this cycle.
REQ-010 Port: wf_switch_en_in  input  1  compute boundary reached; switch permitted.
REQ-011 Port: wf_accept_w_out  output  1  drives pe_accept_w_in of column; weight chain shifts when 1.
REQ-012 Port: wf_weight_out  output  DATA_W  drives pe_weight_in of top PE.
REQ-013 Port: wf_switch_out  output  1  drives pe_switch_in; inactive->active weight swap.
REQ-014 Port: wf_count_out  output  $clog2(ROWS+1)  words accepted in current tile.
REQ-015 Port: wf_busy_out  output  1  state != IDLE.
REQ-016 Port: wf_done_out  output  1  one-cycle pulse, tile switched in.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_SW; state and all outputs except wf_data_ready_out and wf_busy_out SHALL be registered.
REQ-018 IDLE: wf_start_in=1 -> LOAD, count cleared to 0; otherwise remain.
REQ-019 wf_data_ready_out SHALL be 1 exactly when state=LOAD and wf_abort_in=0.
REQ-020 Handshake: word accepted on edge where wf_data_valid_in & wf_data_ready_out; data ignored otherwise.
REQ-021 Accepted word at edge k SHALL appear on wf_weight_out with wf_accept_w_out=1 during cycle k+1 (latency 1).
REQ-022 Cycle after an edge without acceptance: wf_accept_w_out=0, wf_weight_out holds last value (column does not shift on host stall).
REQ-023 Count SHALL increment per accepted word; on acceptance with count=ROWS-1, count becomes ROWS and state -> WAIT_SW.
REQ-024 WAIT_SW: wf_switch_en_in sampled 1 at edge -> wf_switch_out=1 and wf_done_out=1 for exactly the following cycle, state -> IDLE, count -> 0.
REQ-025 wf_switch_out SHALL never be 1 in the same cycle as wf_accept_w_out; earliest switch is 2 cycles after last accepted word.
REQ-026 wf_switch_en_in outside WAIT_SW SHALL be ignored; wf_start_in outside IDLE SHALL be ignored.
REQ-027 wf_abort_in=1 at an edge SHALL force IDLE, count 0, wf_accept_w_out 0, wf_switch_out 0, no done pulse; abort wins over start, handshake and switch_en in same cycle.
REQ-028 wf_start_in and wf_switch_en_in in same cycle while in WAIT_SW: switch taken, start ignored.
REQ-029 No arithmetic on data; wf_weight_out bit-exact copy of wf_data_in.

Reset
REQ-030 While rst=1: state IDLE, count 0, wf_weight_out 0, wf_accept_w_out 0, wf_switch_out 0, wf_done_out 0, wf_data_ready_out 0, wf_busy_out 0, immediately without clock.
REQ-031 Reset mid-tile SHALL discard partial tile; first cycle after deassertion behaves as IDLE.

Verification
REQ-032 ROWS=4, start, host streams 1.0,2.0,3.0,4.0 (0x0100..0x0400) back-to-back, switch_en high -> accept_w high 4 consecutive cycles with those words, then switch_out and done 1 cycle, 2 cycles after last beat.
REQ-033 Host drops valid for 2 cycles after word 2 -> accept_w low those 2 cycles, weight_out holds 0x0200, count stays 2, total still 4 shifts.
REQ-034 Tile loaded, switch_en low 5 cycles then high -> busy=1, ready=0, switch_out 0 throughout wait; single switch pulse cycle after switch_en sampled.
REQ-035 Abort after 2 words (and abort with simultaneous start/switch_en) -> IDLE next cycle, count 0, no switch_out, no done.
REQ-036 rst asserted mid-LOAD between clock edges -> all outputs 0 immediately; new tile after release loads normally.
REQ-037 start while busy and switch_en in IDLE/LOAD -> no effect on state, count or outputs.
